// File: rtl/mapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mapper_pkg
// Description : Shared constants for the segment mapper: MAP / EOM opcodes,
//               megabyte-select key, sequencer state encoding and readback
//               selector codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mapper_pkg;

    // Opcodes observed on the CPU read bus during opcode fetch
    localparam logic [7:0] c_op_map = 8'h5C;
    localparam logic [7:0] c_op_eom = 8'hEA;

    // An X (or Z) operand equal to this value redirects A (or Y) into the
    // megabyte-select register instead of the offset/enable registers
    localparam logic [7:0] c_mb_key = 8'h0F;

    // MAP sequencer state encoding
    localparam int         c_state_w   = 3;
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_cap_a  = 3'd1;
    localparam logic [2:0] c_st_cap_x  = 3'd2;
    localparam logic [2:0] c_st_cap_y  = 3'd3;
    localparam logic [2:0] c_st_cap_z  = 3'd4;

    // map_reg_sel readback codes
    localparam logic [2:0] c_sel_off_lo = 3'd0;
    localparam logic [2:0] c_sel_ctl_lo = 3'd1;
    localparam logic [2:0] c_sel_off_hi = 3'd2;
    localparam logic [2:0] c_sel_ctl_hi = 3'd3;
    localparam logic [2:0] c_sel_mb_lo  = 3'd4;
    localparam logic [2:0] c_sel_mb_hi  = 3'd5;
    localparam logic [2:0] c_sel_status = 3'd6;
    localparam logic [2:0] c_sel_zero   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/map_seq.sv
`default_nettype none
// ============================================================================
// Module      : map_seq
// Description : MAP instruction sequencer. Detects the MAP opcode, captures
//               the four register operands (A, X, Y, Z) into shadow registers
//               and raises a one-cycle commit strobe. Also owns the interrupt
//               enable that MAP clears and EOM restores.
// Revision    : 1.0 - initial release
// ============================================================================
module map_seq
    import mapper_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic       sync,
    input  logic [7:0] data_i,
    input  logic [7:0] data_o,
    output logic [2:0] state,
    output logic       busy,
    output logic       int_enable,
    output logic       commit,
    output logic [7:0] sh_a,
    output logic [7:0] sh_x,
    output logic [7:0] sh_y,
    output logic [7:0] commit_z
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_next;
    logic                 w_start;
    logic                 w_eom;
    logic [7:0]           r_sh_a;
    logic [7:0]           r_sh_x;
    logic [7:0]           r_sh_y;
    logic                 r_int_enable;

    // Opcode decode is only meaningful on a completed fetch cycle in IDLE
    assign w_start = (r_state == c_st_idle) && ready && sync && (data_i == c_op_map);
    assign w_eom   = (r_state == c_st_idle) && ready && sync && (data_i == c_op_eom);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_next;
    end

    // Next-state logic: operand states only advance on completed bus cycles
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_start) w_state_next = c_st_cap_a;
            c_st_cap_a: if (ready)   w_state_next = c_st_cap_x;
            c_st_cap_x: if (ready)   w_state_next = c_st_cap_y;
            c_st_cap_y: if (ready)   w_state_next = c_st_cap_z;
            c_st_cap_z: if (ready)   w_state_next = c_st_idle;
            default:                 w_state_next = c_st_idle;
        endcase
    end

    // Output decode: busy outside IDLE, commit on the completed Z cycle
    always_comb begin
        busy   = (r_state != c_st_idle);
        commit = (r_state == c_st_cap_z) && ready;
    end

    // Shadow operand capture and interrupt enable tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_a       <= 8'h00;
            r_sh_x       <= 8'h00;
            r_sh_y       <= 8'h00;
            r_int_enable <= 1'b1;
        end else begin
            if (w_start)    r_int_enable <= 1'b0;
            else if (w_eom) r_int_enable <= 1'b1;
            if (ready) begin
                case (r_state)
                    c_st_cap_a: r_sh_a <= data_o;
                    c_st_cap_x: r_sh_x <= data_o;
                    c_st_cap_y: r_sh_y <= data_o;
                    default: ;
                endcase
            end
        end
    end

    // Z is consumed on the same edge it is presented, so it is forwarded
    // straight from the bus rather than from a shadow register
    assign commit_z   = data_o;
    assign state      = r_state;
    assign int_enable = r_int_enable;
    assign sh_a       = r_sh_a;
    assign sh_x       = r_sh_x;
    assign sh_y       = r_sh_y;

endmodule
`default_nettype wire

// File: rtl/seg_mapper.sv
`default_nettype none
// ============================================================================
// Module      : seg_mapper
// Description : Segment address mapper. Eight 8 KiB logical segments are
//               relocated into a PADDR_W-bit physical space using two
//               offset/megabyte register sets (low and high 32 KiB halves)
//               loaded atomically by the MAP instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_mapper
    import mapper_pkg::*;
#(
    parameter int PADDR_W = 20,
    parameter int MB_EN   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    input  logic               sync,
    input  logic [7:0]         data_i,
    input  logic [7:0]         data_o,
    input  logic [15:0]        core_address_next,
    input  logic               map_enable_ext,
    input  logic               ext_irq,
    input  logic               ext_nmi,
    output logic               cpu_irq,
    output logic               cpu_nmi,
    input  logic [2:0]         map_reg_sel,
    output logic [7:0]         map_reg,
    output logic [PADDR_W-1:0] address_next,
    output logic [PADDR_W-1:0] address,
    output logic               map,
    output logic               map_busy
);

    localparam int c_page_w = PADDR_W - 8;

    logic [2:0]          w_state;
    logic                w_int_enable;
    logic                w_commit;
    logic [7:0]          w_sh_a;
    logic [7:0]          w_sh_x;
    logic [7:0]          w_sh_y;
    logic [7:0]          w_sh_z;
    logic                w_key_lo;
    logic                w_key_hi;

    // offset registers hold offset[19:8]; enable bit n gates segment n
    logic [11:0]         r_off_lo;
    logic [11:0]         r_off_hi;
    logic [7:0]          r_enable;
    logic [7:0]          w_mb_lo8;
    logic [7:0]          w_mb_hi8;
    logic [c_page_w-1:0] w_base_lo;
    logic [c_page_w-1:0] w_base_hi;
    logic [c_page_w-1:0] w_base;
    logic [c_page_w-1:0] w_page;
    logic [2:0]          w_seg;
    logic                w_translate;
    logic [PADDR_W-1:0]  r_address;
    logic                r_map;

    map_seq u_map_seq (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .sync       (sync),
        .data_i     (data_i),
        .data_o     (data_o),
        .state      (w_state),
        .busy       (map_busy),
        .int_enable (w_int_enable),
        .commit     (w_commit),
        .sh_a       (w_sh_a),
        .sh_x       (w_sh_x),
        .sh_y       (w_sh_y),
        .commit_z   (w_sh_z)
    );

    assign w_key_lo = (MB_EN != 0) && (w_sh_x == c_mb_key);
    assign w_key_hi = (MB_EN != 0) && (w_sh_z == c_mb_key);

    // Offset/enable commit; both halves update on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_off_lo <= 12'h000;
            r_off_hi <= 12'h000;
            r_enable <= 8'h00;
        end else if (w_commit) begin
            if (!w_key_lo) begin
                r_off_lo      <= {w_sh_x[3:0], w_sh_a};
                r_enable[3:0] <= w_sh_x[7:4];
            end
            if (!w_key_hi) begin
                r_off_hi      <= {w_sh_z[3:0], w_sh_y};
                r_enable[7:4] <= w_sh_z[7:4];
            end
        end
    end

    // Megabyte-select registers exist only when enabled and the physical
    // space is wider than 1 MiB; otherwise the page base is the offset alone
    generate
        if ((MB_EN != 0) && (PADDR_W > 20)) begin : g_mb_on
            localparam int c_mb_w = PADDR_W - 20;
            logic [c_mb_w-1:0] r_mb_lo;
            logic [c_mb_w-1:0] r_mb_hi;

            // MB commit shares the MAP commit edge with the offset registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_mb_lo <= '0;
                    r_mb_hi <= '0;
                end else if (w_commit) begin
                    if (w_key_lo) r_mb_lo <= w_sh_a[c_mb_w-1:0];
                    if (w_key_hi) r_mb_hi <= w_sh_y[c_mb_w-1:0];
                end
            end

            assign w_mb_lo8  = 8'(r_mb_lo);
            assign w_mb_hi8  = 8'(r_mb_hi);
            assign w_base_lo = {r_mb_lo, r_off_lo};
            assign w_base_hi = {r_mb_hi, r_off_hi};
        end else begin : g_mb_off
            assign w_mb_lo8  = 8'h00;
            assign w_mb_hi8  = 8'h00;
            assign w_base_lo = c_page_w'(r_off_lo);
            assign w_base_hi = c_page_w'(r_off_hi);
        end
    endgenerate

    // Translation: untranslated accesses add a zero base (pass-through)
    assign w_seg       = core_address_next[15:13];
    assign w_translate = r_enable[w_seg] & map_enable_ext;
    assign w_base      = !w_translate        ? '0
                       : core_address_next[15] ? w_base_hi : w_base_lo;
    assign w_page      = w_base + c_page_w'(core_address_next[15:8]);

    assign address_next = ready ? {w_page, core_address_next[7:0]} : r_address;

    // Physical address register advances with the CPU bus cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_address <= '0;
            r_map     <= 1'b0;
        end else if (ready) begin
            r_address <= address_next;
            r_map     <= w_translate;
        end
    end

    assign address = r_address;
    assign map     = r_map;
    assign cpu_irq = ext_irq & w_int_enable;
    assign cpu_nmi = ext_nmi & w_int_enable;

    // Register readback mux
    always_comb begin
        map_reg = 8'h00;
        case (map_reg_sel)
            c_sel_off_lo: map_reg = r_off_lo[7:0];
            c_sel_ctl_lo: map_reg = {r_enable[3:0], r_off_lo[11:8]};
            c_sel_off_hi: map_reg = r_off_hi[7:0];
            c_sel_ctl_hi: map_reg = {r_enable[7:4], r_off_hi[11:8]};
            c_sel_mb_lo:  map_reg = w_mb_lo8;
            c_sel_mb_hi:  map_reg = w_mb_hi8;
            c_sel_status: map_reg = {w_int_enable, 4'b0000, w_state};
            c_sel_zero:   map_reg = 8'h00;
            default:      map_reg = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_mapper
// Description : Directed self-checking bench for seg_mapper. Two instances
//               (PADDR_W=20 and PADDR_W=28) share all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_mapper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b1;
    logic        sync = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic [7:0]  data_o = 8'h00;
    logic [15:0] core = 16'h0000;
    logic        map_en = 1'b1;
    logic        ext_irq = 1'b0;
    logic        ext_nmi = 1'b0;
    logic [2:0]  sel = 3'd0;

    logic        irq20, nmi20, map20, busy20;
    logic [7:0]  reg20;
    logic [19:0] addr20, anext20;
    logic        irq28, nmi28, map28, busy28;
    logic [7:0]  reg28;
    logic [27:0] addr28, anext28;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    seg_mapper #(.PADDR_W(20), .MB_EN(1)) dut20 (
        .clk(clk), .reset(reset), .ready(ready), .sync(sync),
        .data_i(data_i), .data_o(data_o), .core_address_next(core),
        .map_enable_ext(map_en), .ext_irq(ext_irq), .ext_nmi(ext_nmi),
        .cpu_irq(irq20), .cpu_nmi(nmi20), .map_reg_sel(sel), .map_reg(reg20),
        .address_next(anext20), .address(addr20), .map(map20), .map_busy(busy20)
    );

    seg_mapper #(.PADDR_W(28), .MB_EN(1)) dut28 (
        .clk(clk), .reset(reset), .ready(ready), .sync(sync),
        .data_i(data_i), .data_o(data_o), .core_address_next(core),
        .map_enable_ext(map_en), .ext_irq(ext_irq), .ext_nmi(ext_nmi),
        .cpu_irq(irq28), .cpu_nmi(nmi28), .map_reg_sel(sel), .map_reg(reg28),
        .address_next(anext28), .address(addr28), .map(map28), .map_busy(busy28)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] s);
        sel = s;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ready = 1'b1; sync = 1'b0; data_i = 8'h00; data_o = 8'h00;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic do_map(input logic [7:0] a, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] z);
        ready = 1'b1; sync = 1'b1; data_i = 8'h5C; tick();
        sync = 1'b0; data_i = 8'h00;
        data_o = a; tick();
        data_o = x; tick();
        data_o = y; tick();
        data_o = z; tick();
        data_o = 8'h00;
    endtask

    task automatic fetch(input logic [15:0] a);
        core = a; ready = 1'b1; sync = 1'b1; data_i = 8'h00;
        tick();
        sync = 1'b0;
    endtask

    task automatic test_reset();
        ext_irq = 1'b1; ext_nmi = 1'b1; core = 16'h0000;
        do_reset();
        checks++; if (addr20 !== 20'h00000) begin errors++; $display("FAIL reset_addr20 got=%h exp=%h", addr20, 20'h00000); end
        checks++; if (addr28 !== 28'h0000000) begin errors++; $display("FAIL reset_addr28 got=%h exp=%h", addr28, 28'h0000000); end
        checks++; if (map20 !== 1'b0) begin errors++; $display("FAIL reset_map got=%b exp=0", map20); end
        checks++; if (busy20 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy20); end
        checks++; if (irq20 !== 1'b1 || nmi28 !== 1'b1) begin errors++; $display("FAIL reset_irq got=%b%b exp=11", irq20, nmi28); end
        rd(3'd6);
        checks++; if (reg20 !== 8'h80) begin errors++; $display("FAIL reset_status got=%h exp=80", reg20); end
        rd(3'd1);
        checks++; if (reg20 !== 8'h00) begin errors++; $display("FAIL reset_ctl_lo got=%h exp=00", reg20); end
        ext_irq = 1'b0; ext_nmi = 1'b0;
    endtask

    task automatic test_translate();
        do_reset();
        do_map(8'h20, 8'h20, 8'h00, 8'h00);
        checks++; if (busy20 !== 1'b0) begin errors++; $display("FAIL xl_busy got=%b exp=0", busy20); end
        rd(3'd1);
        checks++; if (reg20 !== 8'h20) begin errors++; $display("FAIL xl_ctl_lo got=%h exp=20", reg20); end
        rd(3'd0);
        checks++; if (reg28 !== 8'h20) begin errors++; $display("FAIL xl_off_lo got=%h exp=20", reg28); end
        fetch(16'h2345);
        checks++; if (addr20 !== 20'h04345) begin errors++; $display("FAIL xl_addr20 got=%h exp=04345", addr20); end
        checks++; if (map20 !== 1'b1) begin errors++; $display("FAIL xl_map got=%b exp=1", map20); end
        checks++; if (addr28 !== 28'h0004345) begin errors++; $display("FAIL xl_addr28 got=%h exp=0004345", addr28); end
        fetch(16'h6345);
        checks++; if (addr20 !== 20'h06345 || map20 !== 1'b0) begin errors++; $display("FAIL xl_unmapped got=%h/%b exp=06345/0", addr20, map20); end
        do_map(8'h00, 8'h00, 8'h10, 8'h80);
        rd(3'd3);
        checks++; if (reg20 !== 8'h80) begin errors++; $display("FAIL xl_ctl_hi got=%h exp=80", reg20); end
        fetch(16'hE000);
        checks++; if (addr20 !== 20'h0F000 || map20 !== 1'b1) begin errors++; $display("FAIL xl_hi got=%h/%b exp=0F000/1", addr20, map20); end
        map_en = 1'b0;
        fetch(16'hE000);
        checks++; if (addr20 !== 20'h0E000 || map20 !== 1'b0) begin errors++; $display("FAIL xl_ext_off got=%h/%b exp=0E000/0", addr20, map20); end
        map_en = 1'b1;
    endtask

    task automatic test_ready_hold();
        do_reset();
        fetch(16'h1234);
        ready = 1'b1; sync = 1'b1; data_i = 8'h5C; tick();
        sync = 1'b0; data_i = 8'h00; data_o = 8'h11; tick();
        ready = 1'b0; data_o = 8'hEE; core = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            tick();
            rd(3'd6);
            checks++; if (reg20 !== 8'h02) begin errors++; $display("FAIL hold_state%0d got=%h exp=02", i, reg20); end
            rd(3'd1);
            checks++; if (reg20 !== 8'h00) begin errors++; $display("FAIL hold_ctl%0d got=%h exp=00", i, reg20); end
            checks++; if (anext20 !== 20'h01234) begin errors++; $display("FAIL hold_anext%0d got=%h exp=01234", i, anext20); end
        end
        ready = 1'b1; data_o = 8'h5A; tick();
        data_o = 8'h00; tick();
        rd(3'd1);
        checks++; if (reg20 !== 8'h00) begin errors++; $display("FAIL hold_partial got=%h exp=00", reg20); end
        rd(3'd6);
        checks++; if (reg20 !== 8'h04) begin errors++; $display("FAIL hold_cap_z got=%h exp=04", reg20); end
        tick();
        rd(3'd1);
        checks++; if (reg20 !== 8'h5A) begin errors++; $display("FAIL hold_commit_ctl got=%h exp=5A", reg20); end
        rd(3'd0);
        checks++; if (reg20 !== 8'h11) begin errors++; $display("FAIL hold_commit_off got=%h exp=11", reg20); end
    endtask

    task automatic test_megabyte();
        do_reset();
        do_map(8'h12, 8'h0F, 8'h00, 8'h00);
        rd(3'd4);
        checks++; if (reg28 !== 8'h12) begin errors++; $display("FAIL mb_lo28 got=%h exp=12", reg28); end
        checks++; if (reg20 !== 8'h00) begin errors++; $display("FAIL mb_lo20 got=%h exp=00", reg20); end
        rd(3'd1);
        checks++; if (reg28 !== 8'h00) begin errors++; $display("FAIL mb_keep_ctl got=%h exp=00", reg28); end
        do_map(8'h00, 8'hF0, 8'h00, 8'h00);
        rd(3'd1);
        checks++; if (reg28 !== 8'hF0) begin errors++; $display("FAIL mb_ctl got=%h exp=F0", reg28); end
        fetch(16'h0100);
        checks++; if (addr28 !== 28'h1200100) begin errors++; $display("FAIL mb_addr28 got=%h exp=1200100", addr28); end
        checks++; if (addr20 !== 20'h00100 || map20 !== 1'b1) begin errors++; $display("FAIL mb_addr20 got=%h/%b exp=00100/1", addr20, map20); end
    endtask

    task automatic test_wrap();
        do_reset();
        do_map(8'hFF, 8'h1F, 8'h00, 8'h00);
        fetch(16'h0180);
        checks++; if (addr20 !== 20'h00080) begin errors++; $display("FAIL wrap_addr20 got=%h exp=00080", addr20); end
        checks++; if (addr28 !== 28'h0100080) begin errors++; $display("FAIL wrap_addr28 got=%h exp=0100080", addr28); end
    endtask

    task automatic test_irq();
        do_reset();
        ext_irq = 1'b1; ext_nmi = 1'b1; #1;
        checks++; if (irq20 !== 1'b1) begin errors++; $display("FAIL irq_idle got=%b exp=1", irq20); end
        ready = 1'b1; sync = 1'b1; data_i = 8'h5C; tick();
        checks++; if (irq20 !== 1'b0 || nmi20 !== 1'b0) begin errors++; $display("FAIL irq_map got=%b%b exp=00", irq20, nmi20); end
        sync = 1'b0; data_i = 8'h00; tick();
        sync = 1'b1; data_i = 8'hEA; tick();
        checks++; if (irq20 !== 1'b0) begin errors++; $display("FAIL irq_mid_eom got=%b exp=0", irq20); end
        sync = 1'b0; data_i = 8'h00; tick(); tick();
        checks++; if (irq20 !== 1'b0 || busy20 !== 1'b0) begin errors++; $display("FAIL irq_after_map got=%b/%b exp=0/0", irq20, busy20); end
        sync = 1'b1; data_i = 8'hEA; ready = 1'b0; tick();
        checks++; if (irq20 !== 1'b0) begin errors++; $display("FAIL irq_eom_noready got=%b exp=0", irq20); end
        ready = 1'b1; tick();
        checks++; if (irq20 !== 1'b1 || nmi28 !== 1'b1) begin errors++; $display("FAIL irq_eom got=%b%b exp=11", irq20, nmi28); end
        sync = 1'b0; data_i = 8'h00; ext_irq = 1'b0; #1;
        checks++; if (irq20 !== 1'b0) begin errors++; $display("FAIL irq_ext_low got=%b exp=0", irq20); end
        ext_nmi = 1'b0;
    endtask

    task automatic test_reset_abort();
        do_reset();
        do_map(8'h44, 8'h30, 8'h00, 8'h00);
        rd(3'd0);
        checks++; if (reg20 !== 8'h44) begin errors++; $display("FAIL abort_pre got=%h exp=44", reg20); end
        ready = 1'b1; sync = 1'b1; data_i = 8'h5C; tick();
        sync = 1'b0; data_i = 8'h00; data_o = 8'h55; tick();
        data_o = 8'h66; tick();
        rd(3'd6);
        checks++; if (reg20 !== 8'h03) begin errors++; $display("FAIL abort_cap_y got=%h exp=03", reg20); end
        reset = 1'b1; data_o = 8'h77; tick();
        reset = 1'b0; data_o = 8'h00;
        rd(3'd6);
        checks++; if (reg20 !== 8'h80 || busy20 !== 1'b0) begin errors++; $display("FAIL abort_state got=%h/%b exp=80/0", reg20, busy20); end
        rd(3'd0);
        checks++; if (reg20 !== 8'h00) begin errors++; $display("FAIL abort_off got=%h exp=00", reg20); end
        ready = 1'b1; sync = 1'b1; data_i = 8'h5C; tick();
        sync = 1'b0; data_i = 8'h00; data_o = 8'h33; tick();
        data_o = 8'h24; tick();
        data_o = 8'h00; tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        rd(3'd0);
        checks++; if (reg20 !== 8'h00) begin errors++; $display("FAIL abort_commit_off got=%h exp=00", reg20); end
        rd(3'd1);
        checks++; if (reg20 !== 8'h00) begin errors++; $display("FAIL abort_commit_ctl got=%h exp=00", reg20); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_map(8'h01, 8'h10, 8'h00, 8'h00);
        do_map(8'h02, 8'h10, 8'h00, 8'h00);
        rd(3'd0);
        checks++; if (reg20 !== 8'h02) begin errors++; $display("FAIL b2b_off got=%h exp=02", reg20); end
        fetch(16'h0000);
        checks++; if (addr20 !== 20'h00200) begin errors++; $display("FAIL b2b_addr got=%h exp=00200", addr20); end
    endtask

    initial begin
        test_reset();
        test_translate();
        test_ready_hold();
        test_megabyte();
        test_wrap();
        test_irq();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
